// File: rtl/clock_sel_arbiter.sv
// clock_sel_arbiter
//   Round-robin arbiter for polarity-change requests on a shared clock-polarity mux.
//   A request whose polarity matches the current select is granted immediately. A change
//   is sequenced as: gate off for GUARD_CYCLES, flip sel, gate off for GUARD_CYCLES more,
//   re-enable the gate together with the grant, then hold the new polarity for DWELL_CYCLES
//   before arbitrating again.
//   Optional feature: define SEL_LOCK_EN to add lock_i, which freezes arbitration in idle.
// Ports
//   clk_in_i        system clock, rising edge
//   rst_i           synchronous active-high reset
//   lock_i          (SEL_LOCK_EN only) 1 = no arbitration while idle
//   req_i           per-requester request, held until granted
//   req_pol_i       requested polarity per requester (0 = clk, 1 = inverted clk)
//   grant_o         one-hot single-cycle grant pulse, registered
//   sel_o           clock mux select, registered
//   clk_gate_en_o   downstream clock gate enable, registered
//   busy_o          high whenever a switch sequence is in progress
module clock_sel_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned DWELL_CYCLES = 8
) (
  input  logic               clk_in_i,
  input  logic               rst_i,
`ifdef SEL_LOCK_EN
  input  logic               lock_i,
`endif
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] req_pol_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               sel_o,
  output logic               clk_gate_en_o,
  output logic               busy_o
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned MaxCnt = (GUARD_CYCLES > DWELL_CYCLES) ? GUARD_CYCLES : DWELL_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] GuardLoad = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StGuardPre, StSwitch, StGuardPost, StDwell} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      win_q, win_d;
  logic                 pol_q, pol_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 sel_q, sel_d;
  logic                 gate_q, gate_d;

  logic                 lock_w;
  logic                 arb_found;
  logic [IdxW-1:0]      arb_idx;
  logic                 gnt_evt;
  logic [IdxW-1:0]      gnt_idx;

`ifdef SEL_LOCK_EN
  assign lock_w = lock_i;
`else
  assign lock_w = 1'b0;
`endif

  // Round-robin search starting at rr_q.
  always_comb begin
    int unsigned k;
    logic [IdxW-1:0] cand;
    k         = 0;
    cand      = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(rr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      cand = IdxW'(k);
      if (!arb_found && req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_in_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      win_q   <= '0;
      pol_q   <= 1'b0;
      rr_q    <= '0;
      grant_q <= '0;
      sel_q   <= 1'b0;
      gate_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      pol_q   <= pol_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
    end
  end

  // Next-state: phase counters reload on each phase entry and count down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    pol_d   = pol_q;
    rr_d    = rr_q;
    gnt_evt = 1'b0;
    gnt_idx = win_q;
    unique case (state_q)
      StIdle: begin
        if (!lock_w && arb_found) begin
          if (req_pol_i[arb_idx] == sel_q) begin
            gnt_evt = 1'b1;
            gnt_idx = arb_idx;
          end else begin
            state_d = StGuardPre;
            cnt_d   = GuardLoad;
            win_d   = arb_idx;
            pol_d   = req_pol_i[arb_idx];
          end
        end
      end
      StGuardPre: begin
        if (cnt_q == '0) state_d = StSwitch;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StSwitch: begin
        state_d = StGuardPost;
        cnt_d   = GuardLoad;
      end
      StGuardPost: begin
        if (cnt_q == '0) begin
          state_d = StDwell;
          cnt_d   = DwellLoad;
          gnt_evt = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDwell: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
    // Pointer advances only when the grant is actually issued.
    if (gnt_evt) begin
      rr_d = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  // Outputs: registered next values derived from the transition being taken.
  always_comb begin
    sel_d   = sel_q;
    grant_d = '0;
    if (state_q == StGuardPre && state_d == StSwitch) sel_d = pol_q;
    // Gate is off throughout pre-guard, switch and post-guard, so sel only moves while gated.
    gate_d  = !(state_d inside {StGuardPre, StSwitch, StGuardPost});
    if (gnt_evt) grant_d[gnt_idx] = 1'b1;
  end

  assign grant_o       = grant_q;
  assign sel_o         = sel_q;
  assign clk_gate_en_o = gate_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_clock_sel_arbiter.sv
// Directed bench for clock_sel_arbiter (NUM_REQ=2, GUARD_CYCLES=2, DWELL_CYCLES=8).
// Expected per-cycle outputs are queued when stimulus is applied and popped one per clock.
module tb_clock_sel_arbiter;

  localparam int G = 2;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic [1:0] req;
  logic [1:0] req_pol;
  logic [1:0] grant;
  logic       sel;
  logic       gate;
  logic       busy;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  typedef struct packed {
    logic [7:0] cyc;
    logic [1:0] grant;
    logic       sel;
    logic       gate;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  clock_sel_arbiter #(
    .NUM_REQ      (2),
    .GUARD_CYCLES (G),
    .DWELL_CYCLES (D)
  ) dut (
    .clk_in_i      (clk),
    .rst_i         (rst),
`ifdef SEL_LOCK_EN
    .lock_i        (lock),
`endif
    .req_i         (req),
    .req_pol_i     (req_pol),
    .grant_o       (grant),
    .sel_o         (sel),
    .clk_gate_en_o (gate),
    .busy_o        (busy)
  );

  function automatic exp_t mk(int c, logic [1:0] g, logic s, logic ge, logic b);
    exp_t e;
    e.cyc   = 8'(c);
    e.grant = g;
    e.sel   = s;
    e.gate  = ge;
    e.busy  = b;
    return e;
  endfunction

  // Expected outputs at cycle c for a polarity switch won at cycle t.
  function automatic exp_t sw_exp(int c, int t, logic [1:0] g, logic old_sel);
    exp_t e;
    e.cyc   = 8'(c);
    e.gate  = !(c >= t + 1 && c <= t + 1 + 2 * G);
    e.sel   = (c >= t + 1 + G) ? ~old_sel : old_sel;
    e.grant = (c == t + 2 + 2 * G) ? g : 2'b00;
    e.busy  = (c >= t + 1 && c <= t + 1 + 2 * G + D);
    return e;
  endfunction

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL %s queue_empty got=0 exp=>0", phase);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        assert (grant === e.grant) else begin
          bad++;
          $error("FAIL %s c%0d grant got=%b exp=%b", phase, e.cyc, grant, e.grant);
        end
        total++;
        assert (sel === e.sel) else begin
          bad++;
          $error("FAIL %s c%0d sel got=%b exp=%b", phase, e.cyc, sel, e.sel);
        end
        total++;
        assert (gate === e.gate) else begin
          bad++;
          $error("FAIL %s c%0d clk_gate_en got=%b exp=%b", phase, e.cyc, gate, e.gate);
        end
        total++;
        assert (busy === e.busy) else begin
          bad++;
          $error("FAIL %s c%0d busy got=%b exp=%b", phase, e.cyc, busy, e.busy);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    sb.push_back(mk(1, 2'b00, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(2, 2'b00, 1'b0, 1'b1, 1'b0));
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst     = 1'b1;
    lock    = 1'b0;
    req     = 2'b00;
    req_pol = 2'b00;

    // Reset values.
    phase = "reset";
    do_reset();

    // Same polarity: immediate grant, gate and busy untouched. rr -> 1.
    phase = "same_pol";
    req = 2'b01; req_pol = 2'b00;
    sb.push_back(mk(1, 2'b01, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(2, 2'b00, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(3, 2'b00, 1'b0, 1'b1, 1'b0));
    run(1);
    req = 2'b00;
    run(2);

    // Full switch 0 -> 1 by requester 1. rr -> 0, sel = 1.
    phase = "switch";
    req = 2'b10; req_pol = 2'b10;
    for (int c = 1; c <= 15; c++) sb.push_back(sw_exp(c, 0, 2'b10, 1'b0));
    run(6);
    req = 2'b00;
    run(9);

    // Both held high with matching polarity: grants must alternate.
    phase = "rotate";
    req = 2'b11; req_pol = 2'b11;
    sb.push_back(mk(1, 2'b01, 1'b1, 1'b1, 1'b0));
    sb.push_back(mk(2, 2'b10, 1'b1, 1'b1, 1'b0));
    sb.push_back(mk(3, 2'b01, 1'b1, 1'b1, 1'b0));
    sb.push_back(mk(4, 2'b10, 1'b1, 1'b1, 1'b0));
    sb.push_back(mk(5, 2'b00, 1'b1, 1'b1, 1'b0));
    run(4);
    req = 2'b00;
    run(1);

    // After reset, both request: req0 (same pol) first, then req1 switches from cycle 1.
    phase = "reset2";
    do_reset();
    phase = "two_req";
    req = 2'b11; req_pol = 2'b10;
    for (int c = 1; c <= 16; c++) begin
      e = sw_exp(c, 1, 2'b10, 1'b0);
      if (c == 1) e.grant = 2'b01;
      sb.push_back(e);
    end
    run(1);
    req = 2'b10;
    run(6);
    req = 2'b00;
    run(9);

    // Switch 1 -> 0 with requester dropping after winning; req0 arrives while busy.
    phase = "pending";
    req = 2'b10; req_pol = 2'b00;
    for (int c = 1; c <= 16; c++) begin
      e = sw_exp(c, 0, 2'b10, 1'b1);
      if (c == 15) e.grant = 2'b01;
      sb.push_back(e);
    end
    run(1);
    req = 2'b00;
    run(2);
    req = 2'b01;
    run(12);
    req = 2'b00;
    run(1);

    // Reset in the middle of a switch aborts it.
    phase = "mid_reset";
    req = 2'b10; req_pol = 2'b10;
    for (int c = 1; c <= 4; c++) sb.push_back(sw_exp(c, 0, 2'b10, 1'b0));
    sb.push_back(mk(5, 2'b00, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(6, 2'b00, 1'b0, 1'b1, 1'b0));
    run(4);
    rst = 1'b1;
    req = 2'b00;
    run(1);
    rst = 1'b0;
    run(1);

`ifdef SEL_LOCK_EN
    // Lock holds off arbitration; grant follows the first unlocked cycle.
    phase = "lock";
    lock = 1'b1;
    req = 2'b01; req_pol = 2'b00;
    for (int c = 1; c <= 10; c++) sb.push_back(mk(c, 2'b00, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(11, 2'b01, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(12, 2'b00, 1'b0, 1'b1, 1'b0));
    run(10);
    lock = 1'b0;
    run(1);
    req = 2'b00;
    run(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
